// File: rtl/board_scan_reader.sv
// rtl/board_scan_reader.sv - walks the 64 board squares and streams {x, y, piece} to the renderer.
// Optional BOARD_SCAN_SKIP_UNCHANGED_EN: skip squares whose code matches the last emitted scan.
module board_scan_reader #(
  parameter int READ_LATENCY = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       full_refresh,
  output logic [5:0] mem_address,
  input  logic [3:0] mem_data,
  output logic       sq_valid,
  input  logic       sq_ready,
  output logic [2:0] sq_x,
  output logic [2:0] sq_y,
  output logic [3:0] sq_piece,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, OFFER, DONE} state_t;

  localparam logic [1:0] WAIT_LOAD = 2'(READ_LATENCY - 1);

  state_t     state, next_state;
  logic [5:0] idx;
  logic [1:0] wait_cnt;
  logic [3:0] piece_q;
  logic       wait_last;
  logic       skip;
  logic       xfer;

  assign wait_last = (state == WAIT) && (wait_cnt == 2'd0);
  assign xfer      = (state == OFFER) && sq_ready;

`ifdef BOARD_SCAN_SKIP_UNCHANGED_EN
  logic [3:0] shadow [64];
  logic       shadow_valid;
  logic       refresh_q;

  assign skip = shadow_valid && !refresh_q && (mem_data == shadow[idx]);

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_valid <= 1'b0;
      refresh_q    <= 1'b0;
      for (int i = 0; i < 64; i++) shadow[i] <= 4'd0;
    end else begin
      if (state == IDLE && start) refresh_q <= full_refresh;
      if (state == DONE) shadow_valid <= 1'b1;
      if (xfer) shadow[idx] <= piece_q;
    end
  end
`else
  logic unused_full_refresh;
  assign unused_full_refresh = full_refresh;
  assign skip = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // idx wraps from 63 to 0 on the final advance, leaving it ready for the next scan.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx      <= 6'd0;
      wait_cnt <= 2'd0;
      piece_q  <= 4'd0;
    end else begin
      case (state)
        IDLE:  if (start) idx <= 6'd0;
        ISSUE: wait_cnt <= WAIT_LOAD;
        WAIT: begin
          if (wait_cnt != 2'd0) begin
            wait_cnt <= wait_cnt - 2'd1;
          end else if (skip) begin
            idx <= idx + 6'd1;
          end else begin
            piece_q <= mem_data;
          end
        end
        OFFER: if (sq_ready) idx <= idx + 6'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (start) next_state = ISSUE;
      ISSUE: next_state = WAIT;
      WAIT: begin
        if (wait_last) begin
          if (!skip)            next_state = OFFER;
          else if (idx == 6'd63) next_state = DONE;
          else                  next_state = ISSUE;
        end
      end
      OFFER: begin
        if (xfer) next_state = (idx == 6'd63) ? DONE : ISSUE;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    sq_valid    = (state == OFFER);
    busy        = (state != IDLE);
    done        = (state == DONE);
    mem_address = idx;
    sq_x        = idx[2:0];
    sq_y        = idx[5:3];
    sq_piece    = piece_q;
  end

endmodule

// File: tb/tb_board_scan_reader.sv
// tb/tb_board_scan_reader.sv - scoreboard bench for board_scan_reader at read latency 1 and 2.
module tb_board_scan_reader;

  typedef struct packed {
    logic [9:0] pl;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       a_start, a_fr, a_ready, b_start, b_fr, b_ready;
  logic [5:0] a_addr, b_addr;
  logic [3:0] a_md, b_p, b_md;
  logic       a_valid, b_valid, a_busy, b_busy, a_done, b_done;
  logic [2:0] a_x, a_y, b_x, b_y;
  logic [3:0] a_piece, b_piece;

  logic [3:0] mema [64];
  logic [3:0] memb [64];

  board_scan_reader #(.READ_LATENCY(1)) dut_a (
    .clk(clk), .reset(reset), .start(a_start), .full_refresh(a_fr),
    .mem_address(a_addr), .mem_data(a_md), .sq_valid(a_valid), .sq_ready(a_ready),
    .sq_x(a_x), .sq_y(a_y), .sq_piece(a_piece), .busy(a_busy), .done(a_done)
  );

  board_scan_reader #(.READ_LATENCY(2)) dut_b (
    .clk(clk), .reset(reset), .start(b_start), .full_refresh(b_fr),
    .mem_address(b_addr), .mem_data(b_md), .sq_valid(b_valid), .sq_ready(b_ready),
    .sq_x(b_x), .sq_y(b_y), .sq_piece(b_piece), .busy(b_busy), .done(b_done)
  );

  // Registered memories: one stage for latency 1, two stages for latency 2.
  always @(posedge clk) begin
    a_md <= mema[a_addr];
    b_p  <= memb[b_addr];
    b_md <= b_p;
  end

  int ecount = 0;
  always @(posedge clk) ecount <= ecount + 1;

  int checks = 0, errors = 0;
  int base_a = 0, base_b = 0;
  int xfer_a = 0, xfer_b = 0, done_a = 0, done_b = 0;
  int done_cyc_a = 0, done_cyc_b = 0;
  exp_t qa[$], qb[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (a_valid && a_ready) begin
      xfer_a++;
      if (qa.size() == 0) check("a_unexpected_xfer", 1, 0);
      else begin
        e = qa.pop_front();
        check("a_payload", {a_x, a_y, a_piece}, e.pl);
        if (e.cyc >= 0) check("a_xfer_cycle", ecount - base_a + 1, e.cyc);
      end
    end
    if (b_valid && b_ready) begin
      xfer_b++;
      if (qb.size() == 0) check("b_unexpected_xfer", 1, 0);
      else begin
        e = qb.pop_front();
        check("b_payload", {b_x, b_y, b_piece}, e.pl);
        if (e.cyc >= 0) check("b_xfer_cycle", ecount - base_b + 1, e.cyc);
      end
    end
    if (a_done) begin done_a++; done_cyc_a = ecount - base_a + 1; end
    if (b_done) begin done_b++; done_cyc_b = ecount - base_b + 1; end
  end

  task automatic push_exp(input bit b, input int k, input int cyc);
    exp_t e;
    logic [5:0] a;
    a = 6'(k);
    e.pl  = {a[2:0], a[5:3], (b ? memb[a] : mema[a])};
    e.cyc = cyc;
    if (b) qb.push_back(e);
    else   qa.push_back(e);
  endtask

  task automatic push_all(input bit b, input int first, input int step);
    for (int k = 0; k < 64; k++) push_exp(b, k, (first < 0) ? -1 : first + step * k);
  endtask

  task automatic pulse_start(input bit b, input bit fr);
    @(posedge clk); #1;
    if (b) begin b_start = 1'b1; b_fr = fr; end
    else   begin a_start = 1'b1; a_fr = fr; end
    @(posedge clk); #1;
    a_start = 1'b0;
    b_start = 1'b0;
    if (b) base_b = ecount;
    else   base_a = ecount;
  endtask

  task automatic wait_idle(input bit b, input int limit, output int fall);
    int n;
    n = 0;
    @(negedge clk);
    while ((b ? b_busy : a_busy) && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (n >= limit) check(b ? "b_idle_timeout" : "a_idle_timeout", 0, 1);
    fall = ecount - (b ? base_b : base_a) + 1;
  endtask

  // Stops at the negedge of the ISSUE cycle for address adr.
  task automatic wait_issue_a(input logic [5:0] adr);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(a_addr == adr && !a_valid && a_busy) && n < 1000);
    if (n >= 1000) check("a_issue_timeout", 0, 1);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int fall, d0, x0, n;
    reset = 1'b1;
    a_start = 0; a_fr = 0; a_ready = 1;
    b_start = 0; b_fr = 0; b_ready = 1;
    for (int i = 0; i < 64; i++) begin
      mema[i] = 4'(i);
      memb[i] = 4'(i * 7 + 3);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", a_valid, 0);
    check("rst_busy", a_busy, 0);
    check("rst_done", a_done, 0);
    check("rst_addr", a_addr, 0);
    check("rst_xy", {a_x, a_y}, 0);
    check("rst_piece", a_piece, 0);
    check("rst_b", {b_valid, b_busy, b_done, b_addr, b_piece}, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Full scan, latency 1, ready held high.
    d0 = done_a;
    push_all(0, 3, 3);
    pulse_start(0, 0);
    wait_idle(0, 400, fall);
    check("a_scan_left", qa.size(), 0);
    check("a_done_count", done_a - d0, 1);
    check("a_done_cycle", done_cyc_a, 193);
    check("a_busy_fall", fall, 194);

    // Backpressure on square 10, plus ignored start pulses.
    d0 = done_a; x0 = xfer_a;
    push_all(0, -1, 0);
    pulse_start(0, 1);
    wait_issue_a(6'd10);
    @(posedge clk); #1 a_ready = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", a_valid, 1);
      check("bp_xy", {a_x, a_y}, {3'd2, 3'd1});
      check("bp_piece", a_piece, 10);
      check("bp_addr", a_addr, 10);
    end
    @(posedge clk); #1 a_ready = 1'b1;
    @(negedge clk);
    check("bp_xfer_valid", a_valid, 1);
    @(negedge clk);
    check("bp_valid_drop", a_valid, 0);
    repeat (2) @(negedge clk);
    check("bp_next_valid", a_valid, 1);
    check("bp_next_x", a_x, 3);
    @(posedge clk); #1 a_start = 1'b1;
    @(posedge clk); #1 a_start = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!a_done && n < 400);
    if (n >= 400) check("a_done_timeout", 0, 1);
    #1 a_start = 1'b1;
    @(posedge clk); #1 a_start = 1'b0;
    repeat (3) @(negedge clk);
    check("ign_busy", a_busy, 0);
    check("ign_left", qa.size(), 0);
    check("ign_xfers", xfer_a - x0, 64);
    check("ign_done_count", done_a - d0, 1);

    // Reset while square 20 is offered.
    d0 = done_a;
    push_all(0, -1, 0);
    pulse_start(0, 0);
    wait_issue_a(6'd20);
    @(posedge clk); #1 a_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rs_offer_valid", a_valid, 1);
    check("rs_offer_xy", {a_x, a_y}, {3'd4, 3'd2});
    #1 reset = 1'b1;
    @(negedge clk);
    check("rs_valid", a_valid, 0);
    check("rs_busy", a_busy, 0);
    check("rs_done", a_done, 0);
    qa.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    a_ready = 1'b1;
    push_all(0, 3, 3);
    pulse_start(0, 0);
    wait_idle(0, 400, fall);
    check("rs_scan_left", qa.size(), 0);
    check("rs_done_count", done_a - d0, 1);
    check("rs_done_cycle", done_cyc_a, 193);

`ifdef BOARD_SCAN_SKIP_UNCHANGED_EN
    mema[52] = 4'd0;
    mema[36] = 4'd7;
    x0 = xfer_a;
    push_exp(0, 36, -1);
    push_exp(0, 52, -1);
    pulse_start(0, 0);
    wait_idle(0, 400, fall);
    check("skip_left", qa.size(), 0);
    check("skip_xfers", xfer_a - x0, 2);
    x0 = xfer_a;
    push_all(0, 3, 3);
    pulse_start(0, 1);
    wait_idle(0, 400, fall);
    check("refresh_left", qa.size(), 0);
    check("refresh_xfers", xfer_a - x0, 64);
`endif

    // Latency 2 instance.
    d0 = done_b;
    push_all(1, 4, 4);
    pulse_start(1, 0);
    wait_idle(1, 400, fall);
    check("b_scan_left", qb.size(), 0);
    check("b_done_count", done_b - d0, 1);
    check("b_done_cycle", done_cyc_b, 257);
    check("b_busy_fall", fall, 258);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/board_scan_reader.md
Name: board_scan_reader

Overview:
- Read side of the board memory; the datapath is the writer.
- On request, walks all 64 squares in address order and reads each 4-bit piece code through one memory read port.
- Decodes each address back to (x,y) and hands {x, y, piece} to the renderer over a valid/ready handshake.
- Runs in the view path, driving view_x/view_y and feeding the pixel renderer.

Parameters:
- READ_LATENCY, 1: cycles from mem_address presented until mem_data valid (1 or 2 legal).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  begin a scan; sampled only in IDLE
- full_refresh  in  1  sampled with start; forces emission of all squares (see Optional Feature)
- mem_address  out  6  board address = {y[2:0], x[2:0]} = y*8 + x
- mem_data  in  4  piece code, valid READ_LATENCY cycles after address
- sq_valid  out  1  square payload valid
- sq_ready  in  1  renderer accepts
- sq_x  out  3  square column
- sq_y  out  3  square row
- sq_piece  out  4  piece code (0 empty, 1-6 black, 7-12 white)
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at scan end

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset values: all outputs 0, index 0, state IDLE. Reset wins over every other input in the same cycle.
- Address generation: 6-bit idx register. mem_address = idx, sq_x = idx[2:0], sq_y = idx[5:3]. x varies fastest, order 0..63.
- IDLE: on start=1, load idx=0 and go to ISSUE. start in any other state is ignored, including the DONE cycle.
- ISSUE (1 cycle): mem_address = idx. Go to WAIT.
- WAIT (READ_LATENCY cycles): down-counter. On the last WAIT cycle's edge, latch mem_data into sq_piece and go to OFFER.
- OFFER:
  - sq_valid=1.
  - sq_x, sq_y, sq_piece and mem_address are held stable until the transfer (sq_valid & sq_ready at the edge).
  - On transfer: if idx==63 go to DONE, else idx+1 and go to ISSUE.
  - sq_valid drops in the cycle after the transfer.
- DONE (1 cycle): done=1, busy=1. Then go to IDLE; idx wraps to 0.
- Timing, sq_ready held high:
  - sq_valid first high in cycle READ_LATENCY+2 after the edge that sampled start.
  - Each square costs READ_LATENCY+2 cycles.
  - Full scan is 64*(READ_LATENCY+2) cycles, plus 1 DONE cycle.
- Empty squares (piece 0) are always forwarded so the renderer clears them. Codes 13-15 are forwarded unchanged.
- sq_ready low outside OFFER has no effect. sq_ready high outside OFFER is not a transfer.

Optional Feature:
- Macro: BOARD_SCAN_SKIP_UNCHANGED_EN.
- Defined:
  - Keep a 64x4 shadow of the last emitted codes plus a shadow_valid flag, cleared by reset.
  - At the end of WAIT, if shadow_valid=1, full_refresh was 0 at start, and mem_data equals shadow[idx]: skip OFFER. Advance idx (or go to DONE if idx==63). A skipped square costs READ_LATENCY+1 cycles.
  - Every transfer writes shadow[idx]=sq_piece.
  - shadow_valid is set when DONE is reached.
  - Reset mid-scan clears shadow_valid, so the next scan emits all 64 squares.
- Undefined: no shadow storage. Every square is emitted on every scan, and full_refresh is ignored.

Test Plan:
- Reset, memory preloaded mem[i]=i[3:0], READ_LATENCY=1, sq_ready=1, start pulse at edge 0 -> sq_valid high in cycle 3 with (x0,y0,piece0). Square k transfers in cycle 3+3k: k=9 gives x1,y1,piece9. done pulses in cycle 193; busy falls in cycle 194.
- Backpressure: hold sq_ready=0 for 5 cycles while square 10 is offered -> sq_valid stays 1 and sq_x=2, sq_y=1, sq_piece=10, mem_address=10 stay stable. Square 10 transfers exactly once; square 11 follows 3 cycles after the transfer.
- start pulses while busy and during the done cycle -> ignored. Exactly 64 transfers and one done pulse.
- Reset asserted while square 20 is in OFFER -> next cycle sq_valid=0, busy=0, done=0, no done pulse. A new start emits square 0 first and all 64 squares.
- SKIP_UNCHANGED_EN: complete one scan, then datapath writes mem[52]=0 and mem[36]=7, then start -> only (x4,y4,7) then (x4,y6,0) are transferred, then done. The same sequence with full_refresh=1 -> all 64 transferred.
- READ_LATENCY=2, sq_ready=1 -> first sq_valid in cycle 4, squares every 4 cycles. The captured sq_piece matches mem_data sampled 2 cycles after the address.
